// File: rtl/fs_bist_checker.sv
// fs_bist_checker: exhaustive BIST for a 1-bit full subtractor (walks all 8 vectors, counts mismatches).
// Optional first-fail capture (fail_vec/fail_valid) is enabled by FS_BIST_FIRST_FAIL_EN.
module fs_bist_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             bin_o,
  input  logic             d_i,
  input  logic             bout_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef FS_BIST_FIRST_FAIL_EN
  ,
  output logic [2:0]       fail_vec,
  output logic             fail_valid
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
  state_t state, state_n;
  logic [2:0] idx, idx_n, stim, stim_n;
  logic [7:0] cnt, cnt_n;
  logic [ERR_W-1:0] err_n;
  logic d_exp, bout_exp, miss, sample;
  assign {a_o, b_o, bin_o} = stim;
  assign d_exp = ^idx;
  assign bout_exp = (~idx[2] & idx[1]) | (~idx[2] & idx[0]) | (idx[1] & idx[0]);
  assign miss = (d_i != d_exp) || (bout_i != bout_exp);
  assign sample = (state == RUN) && (cnt == 8'd0);
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && (err_count == '0);
  always_comb begin
    state_n = state;
    idx_n = idx;
    stim_n = stim;
    cnt_n = cnt;
    err_n = err_count;
    if (state != RUN && start) begin
      state_n = RUN;
      idx_n = 3'd0;
      stim_n = 3'd0;
      cnt_n = SETTLE;
      err_n = '0;
    end else if (state == RUN && cnt != 8'd0) begin
      cnt_n = cnt - 8'd1;
    end else if (sample) begin
      err_n = (miss && !(&err_count)) ? err_count + ERR_W'(1'b1) : err_count;
      if (idx != 3'd7) begin
        idx_n = idx + 3'd1;
        stim_n = idx + 3'd1;
        cnt_n = SETTLE;
      end else begin
        state_n = DONE;
        stim_n = 3'd0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 3'd0;
      stim <= 3'd0;
      cnt <= 8'd0;
      err_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      stim <= stim_n;
      cnt <= cnt_n;
      err_count <= err_n;
    end
  end
`ifdef FS_BIST_FIRST_FAIL_EN
  logic [2:0] fv_n;
  logic fvalid_n;
  always_comb begin
    fv_n = fail_vec;
    fvalid_n = fail_valid;
    if (state != RUN && start) begin
      fvalid_n = 1'b0;
    end else if (sample && miss && !fail_valid) begin
      fv_n = idx;
      fvalid_n = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec <= 3'd0;
      fail_valid <= 1'b0;
    end else begin
      fail_vec <= fv_n;
      fail_valid <= fvalid_n;
    end
  end
`endif
endmodule
